modbus_crc_tx_seq: RTL and testbench

//  Frame sequencer between a byte-stream source and the UART transmitter.

---
 rtl/modbus_crc_tx_seq_pkg.sv | 29 ++
 rtl/modbus_crc_tx_seq_down_counter.sv | 31 +++
 rtl/modbus_crc_tx_seq.sv | 176 +++++++++++++++++
 tb/tb_modbus_crc_tx_seq.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modbus_crc_tx_seq_pkg.sv
// Shared definitions for the Modbus CRC transmit sequencer.
//   - Default timing constants (CRC engine settle time, inter-frame silence, max payload).
//   - Sequencer state encoding.
//   - Counter width helper that stays legal for a zero maximum.
package modbus_crc_tx_seq_pkg;

  localparam int unsigned CRC_WAIT_DEF   = 17;
  localparam int unsigned MODBUS_GAP_DEF = 1750;
  localparam int unsigned MAX_LEN_DEF    = 256;

  typedef enum logic [3:0] {
    StIdle,
    StInit,
    StWaitByte,
    StByte,
    StWaitBoth,
    StCrcL,
    StWaitTxL,
    StCrcH,
    StWaitTxH,
    StGap
  } state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/modbus_crc_tx_seq_down_counter.sv
// Loadable down counter that stops at zero.
//   i_clk      : clock
//   i_rst      : synchronous reset, active-high (count -> 0)
//   i_load     : load i_load_val this cycle (priority over decrement)
//   i_load_val : value to load
//   o_zero     : count is zero
module modbus_crc_tx_seq_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/modbus_crc_tx_seq.sv
// Modbus RTU frame sequencer between a byte source and a UART transmitter.
// Each frame: init the CRC16 engine, then per payload byte pulse crc_load and tx_start together,
// wait for both the CRC engine and the UART, and finally append CRC low then high byte.
// A minimum silence follows every frame before the next one may start.
//   i_clk, i_rst                    : clock, synchronous active-high reset
//   i_s_valid/i_s_data/i_s_last     : payload byte stream in, o_s_ready handshake
//   o_crc_init/o_crc_load/o_crc_byte: CRC engine control, i_crc_l/i_crc_h its result
//   o_tx_start/o_tx_data/i_tx_busy  : UART transmitter interface
//   o_busy       : frame in progress (acceptance through end of silence)
//   o_frame_done : pulse once CRC high byte has been taken by the UART
//   o_err_len    : frame was cut at MAX_LEN bytes without s_last; held until next frame start
module modbus_crc_tx_seq
  import modbus_crc_tx_seq_pkg::*;
#(
  parameter int unsigned CRC_WAIT   = CRC_WAIT_DEF,
  parameter int unsigned GAP_CYCLES = MODBUS_GAP_DEF,
  parameter int unsigned MAX_LEN    = MAX_LEN_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_s_valid,
  input  logic [7:0] i_s_data,
  input  logic       i_s_last,
  output logic       o_s_ready,
  output logic       o_crc_init,
  output logic       o_crc_load,
  output logic [7:0] o_crc_byte,
  input  logic [7:0] i_crc_l,
  input  logic [7:0] i_crc_h,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_busy,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_err_len
);

  localparam int unsigned CntW  = $clog2(MAX_LEN + 1);
  localparam int unsigned WaitW = cnt_width(CRC_WAIT);
  localparam int unsigned GapW  = cnt_width(GAP_CYCLES);

  // The wait counter is loaded in BYTE and checked from the next cycle on, so loading
  // CRC_WAIT-1 lets the following load land exactly CRC_WAIT+2 cycles after this one
  // while the CRC result is already stable when CRCL latches it.
  localparam logic [WaitW-1:0] WaitLoad = WaitW'((CRC_WAIT > 0) ? CRC_WAIT - 1 : 0);
  localparam logic [GapW-1:0]  GapLoad  = GapW'(GAP_CYCLES);
  localparam logic [CntW-1:0]  MaxCnt   = CntW'(MAX_LEN);

  state_e          r_state, w_state_next;
  logic [7:0]      r_tx_data, r_crc_byte;
  logic            r_last;
  logic [CntW-1:0] r_cnt;
  logic            r_err_len;
  logic            r_tx_started;  // tx_start was high last cycle: tx_busy not yet trustworthy
  logic            r_frame_done;

  logic w_s_ready, w_crc_init, w_crc_load, w_tx_start;
  logic w_wait_load, w_gap_load, w_wait_zero, w_gap_zero;
  logic w_hs, w_tx_idle;

  assign w_tx_idle = ~r_tx_started & ~i_tx_busy;
  assign w_hs      = (r_state == StWaitByte) & i_s_valid & ~i_tx_busy;

  always_comb begin
    w_state_next = r_state;
    w_s_ready    = 1'b0;
    w_crc_init   = 1'b0;
    w_crc_load   = 1'b0;
    w_tx_start   = 1'b0;
    w_wait_load  = 1'b0;
    w_gap_load   = 1'b0;
    unique case (r_state)
      StIdle:     if (i_s_valid) w_state_next = StInit;
      StInit: begin
        w_crc_init   = 1'b1;
        w_state_next = StWaitByte;
      end
      StWaitByte: begin
        w_s_ready = ~i_tx_busy;
        if (w_hs) w_state_next = StByte;
      end
      StByte: begin
        w_crc_load   = 1'b1;
        w_tx_start   = 1'b1;
        w_wait_load  = 1'b1;
        w_state_next = StWaitBoth;
      end
      StWaitBoth: begin
        if (w_wait_zero && w_tx_idle) begin
          w_state_next = (r_last || (r_cnt == MaxCnt)) ? StCrcL : StWaitByte;
        end
      end
      StCrcL: begin
        w_tx_start   = 1'b1;
        w_state_next = StWaitTxL;
      end
      StWaitTxL:  if (w_tx_idle) w_state_next = StCrcH;
      StCrcH: begin
        w_tx_start   = 1'b1;
        w_state_next = StWaitTxH;
      end
      StWaitTxH: begin
        if (w_tx_idle) begin
          w_gap_load   = 1'b1;
          w_state_next = StGap;
        end
      end
      StGap:      if (w_gap_zero) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_tx_data    <= 8'h00;
      r_crc_byte   <= 8'h00;
      r_last       <= 1'b0;
      r_cnt        <= '0;
      r_err_len    <= 1'b0;
      r_tx_started <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_tx_started <= w_tx_start;
      r_frame_done <= w_gap_load;
      if (r_state == StInit) begin
        r_cnt     <= '0;
        r_err_len <= 1'b0;
      end
      if (w_hs) begin
        r_tx_data  <= i_s_data;
        r_crc_byte <= i_s_data;
        r_last     <= i_s_last;
        if (r_cnt != MaxCnt) r_cnt <= r_cnt + 1'b1;
      end
      // CRC bytes are captured only once the last wait has elapsed.
      if ((r_state == StWaitBoth) && (w_state_next == StCrcL)) begin
        r_tx_data <= i_crc_l;
        if (!r_last) r_err_len <= 1'b1;
      end
      if ((r_state == StWaitTxL) && (w_state_next == StCrcH)) r_tx_data <= i_crc_h;
    end
  end

  modbus_crc_tx_seq_down_counter #(
    .WIDTH (WaitW)
  ) u_wait_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_wait_load),
    .i_load_val (WaitLoad),
    .o_zero     (w_wait_zero)
  );

  modbus_crc_tx_seq_down_counter #(
    .WIDTH (GapW)
  ) u_gap_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_gap_load),
    .i_load_val (GapLoad),
    .o_zero     (w_gap_zero)
  );

  assign o_s_ready    = w_s_ready;
  assign o_crc_init   = w_crc_init;
  assign o_crc_load   = w_crc_load;
  assign o_crc_byte   = r_crc_byte;
  assign o_tx_start   = w_tx_start;
  assign o_tx_data    = r_tx_data;
  assign o_busy       = (r_state != StIdle);
  assign o_frame_done = r_frame_done;
  assign o_err_len    = r_err_len;

endmodule

// File: tb/tb_modbus_crc_tx_seq.sv
// Bench for modbus_crc_tx_seq: bit-serial CRC engine model, UART busy model, directed frames
// with hand-known Modbus CRCs.
module tb_modbus_crc_tx_seq;

  localparam int CW  = 17;
  localparam int GAP = 20;
  localparam int ML  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_ready, crc_init, crc_load, tx_start, busy, frame_done, err_len, tx_busy;
  logic [7:0] crc_byte, tx_data, crc_l, crc_h;

  always #5 clk = ~clk;

  modbus_crc_tx_seq #(
    .CRC_WAIT   (CW),
    .GAP_CYCLES (GAP),
    .MAX_LEN    (ML)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_s_valid    (s_valid),
    .i_s_data     (s_data),
    .i_s_last     (s_last),
    .o_s_ready    (s_ready),
    .o_crc_init   (crc_init),
    .o_crc_load   (crc_load),
    .o_crc_byte   (crc_byte),
    .i_crc_l      (crc_l),
    .i_crc_h      (crc_h),
    .o_tx_start   (tx_start),
    .o_tx_data    (tx_data),
    .i_tx_busy    (tx_busy),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_err_len    (err_len)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // UART model: busy for char_time cycles after each tx_start, logs every byte.
  int         char_time = 0;
  int         u_cnt = 0;
  logic [7:0] tx_log [0:255];
  int         tx_cnt = 0;
  int         ovl = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) begin
      if (tx_cnt < 256) tx_log[tx_cnt] <= tx_data;
      tx_cnt <= tx_cnt + 1;
      u_cnt  <= char_time;
      if (tx_busy) ovl <= ovl + 1;
    end else if (u_cnt != 0) begin
      u_cnt <= u_cnt - 1;
    end
  end
  assign tx_busy = (u_cnt != 0);

  // CRC engine model: one reflected 0xA001 step every second cycle, 16 cycles per byte.
  // Intermediate values are visible on crc_l/crc_h while shifting.
  logic [15:0] crc_q = 16'hFFFF;
  int          sc = 0;
  int          eng_viol = 0;
  always @(posedge clk) begin
    if (rst) begin
      crc_q <= 16'hFFFF;
      sc    <= 0;
    end else begin
      eng_viol <= eng_viol + int'((crc_init || crc_load) && sc != 0) + int'(crc_init && crc_load);
      if (crc_init) begin
        crc_q <= 16'hFFFF;
        sc    <= 0;
      end else if (crc_load) begin
        crc_q <= crc_q ^ {8'h00, crc_byte};
        sc    <= 16;
      end else if (sc != 0) begin
        sc <= sc - 1;
        if (sc[0] == 1'b0) crc_q <= crc_q[0] ? ((crc_q >> 1) ^ 16'hA001) : (crc_q >> 1);
      end
    end
  end
  assign crc_l = crc_q[7:0];
  assign crc_h = crc_q[15:8];

  // Sequence monitor: init/load ordering, load spacing, silence between frames.
  int init_cnt = 0, load_cnt = 0, fd_cnt = 0, order_bad = 0, sp_bad = 0, sp_last = 0;
  int last_load = 0, fd_cyc = 0, gap_len = 0, rdy_hi = 0, gap_rdy = 0;
  bit have_last = 1'b0, armed = 1'b0, win = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      armed     <= 1'b0;
      win       <= 1'b0;
      have_last <= 1'b0;
    end else begin
      if (crc_init) begin
        init_cnt  <= init_cnt + 1;
        have_last <= 1'b0;
        armed     <= 1'b1;
        if (win) begin
          win     <= 1'b0;
          gap_len <= cyc - fd_cyc;
          gap_rdy <= rdy_hi;
        end
      end
      if (crc_load) begin
        load_cnt <= load_cnt + 1;
        if (!armed) order_bad <= order_bad + 1;
        if (have_last) begin
          sp_last <= cyc - last_load;
          if (cyc - last_load < CW + 2) sp_bad <= sp_bad + 1;
        end
        have_last <= 1'b1;
        last_load <= cyc;
      end
      if (frame_done) begin
        fd_cnt <= fd_cnt + 1;
        armed  <= 1'b0;
        win    <= 1'b1;
        fd_cyc <= cyc;
        rdy_hi <= 0;
      end else if (win && s_ready) begin
        rdy_hi <= rdy_hi + 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] pay [0:7];

  task automatic set_pay(input logic [7:0] b0, b1, b2, b3, b4, b5);
    pay[0] = b0; pay[1] = b1; pay[2] = b2; pay[3] = b3; pay[4] = b4; pay[5] = b5;
  endtask

  // Offers pay[first .. first+n-1]; returns just after the last handshake edge.
  task automatic send_bytes(input int first, input int n, input bit last_at_end, output bit ok);
    ok = 1'b1;
    for (int i = first; i < first + n; i++) begin
      int w;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = pay[i];
      s_last  = last_at_end && (i == first + n - 1);
      w = 0;
      while (!s_ready && w < 3000) begin
        @(negedge clk);
        w++;
      end
      if (!s_ready) begin
        ok = 1'b0;
        return;
      end
      @(posedge clk);
    end
  endtask

  task automatic src_idle();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int limit, output bit ok);
    int w = 0;
    while (fd_cnt < target && w < limit) begin
      @(negedge clk);
      w++;
    end
    ok = (fd_cnt >= target);
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int w = 0;
    while (busy && w < limit) begin
      @(negedge clk);
      w++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 9;
    if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (s_ready !== 1'b0)    begin bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    if (crc_init !== 1'b0)   begin bad++; $display("FAIL rst_crc_init: got %b want 0", crc_init); end
    if (crc_load !== 1'b0)   begin bad++; $display("FAIL rst_crc_load: got %b want 0", crc_load); end
    if (tx_start !== 1'b0)   begin bad++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    if (err_len !== 1'b0)    begin bad++; $display("FAIL rst_err_len: got %b want 0", err_len); end
    if (tx_data !== 8'h00)   begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    if (crc_byte !== 8'h00)  begin bad++; $display("FAIL rst_crc_byte: got %h want 00", crc_byte); end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    bit ok;
    int t0, i0, l0, f0;
    logic [7:0] exp [0:7];
    char_time = 0;
    t0 = tx_cnt; i0 = init_cnt; l0 = load_cnt; f0 = fd_cnt;
    set_pay(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A);
    exp[0] = 8'h01; exp[1] = 8'h03; exp[2] = 8'h00; exp[3] = 8'h00;
    exp[4] = 8'h00; exp[5] = 8'h0A; exp[6] = 8'hC5; exp[7] = 8'hCD;
    send_bytes(0, 6, 1'b1, ok);
    src_idle();
    total++;
    if (!ok) begin bad++; $display("FAIL single_send: got timeout want handshake"); end
    wait_fd(f0 + 1, 2000, ok);
    @(negedge clk);
    total++;
    if (!ok) begin bad++; $display("FAIL single_fd_wait: got timeout want frame_done"); end
    total++;
    if (tx_cnt - t0 !== 8) begin bad++; $display("FAIL single_tx_count: got %0d want 8", tx_cnt - t0); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (tx_log[t0 + k] !== exp[k]) begin
        bad++; $display("FAIL single_tx_byte%0d: got %h want %h", k, tx_log[t0 + k], exp[k]);
      end
    end
    total += 8;
    if (fd_cnt - f0 !== 1)    begin bad++; $display("FAIL single_fd_count: got %0d want 1", fd_cnt - f0); end
    if (err_len !== 1'b0)     begin bad++; $display("FAIL single_err_len: got %b want 0", err_len); end
    if (busy !== 1'b1)        begin bad++; $display("FAIL single_busy_gap: got %b want 1", busy); end
    if (init_cnt - i0 !== 1)  begin bad++; $display("FAIL single_init_count: got %0d want 1", init_cnt - i0); end
    if (load_cnt - l0 !== 6)  begin bad++; $display("FAIL single_load_count: got %0d want 6", load_cnt - l0); end
    if (order_bad !== 0)      begin bad++; $display("FAIL single_init_order: got %0d want 0", order_bad); end
    if (sp_last !== CW + 2)   begin bad++; $display("FAIL single_load_spacing: got %0d want %0d", sp_last, CW + 2); end
    if (eng_viol !== 0)       begin bad++; $display("FAIL single_engine: got %0d want 0", eng_viol); end
    wait_idle(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_idle: got busy want idle"); end
  endtask

  task automatic test_slow_uart();
    bit ok;
    int t0, f0;
    logic [7:0] exp [0:7];
    char_time = 100;
    t0 = tx_cnt; f0 = fd_cnt;
    set_pay(8'h11, 8'h03, 8'h00, 8'h6B, 8'h00, 8'h03);
    exp[0] = 8'h11; exp[1] = 8'h03; exp[2] = 8'h00; exp[3] = 8'h6B;
    exp[4] = 8'h00; exp[5] = 8'h03; exp[6] = 8'h76; exp[7] = 8'h87;
    send_bytes(0, 6, 1'b1, ok);
    src_idle();
    total++;
    if (!ok) begin bad++; $display("FAIL slow_send: got timeout want handshake"); end
    wait_fd(f0 + 1, 4000, ok);
    @(negedge clk);
    total++;
    if (!ok) begin bad++; $display("FAIL slow_fd_wait: got timeout want frame_done"); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (tx_log[t0 + k] !== exp[k]) begin
        bad++; $display("FAIL slow_tx_byte%0d: got %h want %h", k, tx_log[t0 + k], exp[k]);
      end
    end
    total += 4;
    if (tx_cnt - t0 !== 8) begin bad++; $display("FAIL slow_tx_count: got %0d want 8", tx_cnt - t0); end
    if (ovl !== 0)         begin bad++; $display("FAIL slow_tx_while_busy: got %0d want 0", ovl); end
    if (sp_last < 100)     begin bad++; $display("FAIL slow_load_spacing: got %0d want >=100", sp_last); end
    if (eng_viol !== 0)    begin bad++; $display("FAIL slow_engine: got %0d want 0", eng_viol); end
    wait_idle(500, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL slow_idle: got busy want idle"); end
    char_time = 0;
  endtask

  task automatic test_back_to_back();
    bit ok, ok2;
    int t0, f0;
    logic [7:0] exp [0:15];
    char_time = 0;
    t0 = tx_cnt; f0 = fd_cnt;
    exp[0]  = 8'h01; exp[1]  = 8'h03; exp[2]  = 8'h00; exp[3]  = 8'h00;
    exp[4]  = 8'h00; exp[5]  = 8'h01; exp[6]  = 8'h84; exp[7]  = 8'h0A;
    exp[8]  = 8'h01; exp[9]  = 8'h03; exp[10] = 8'h00; exp[11] = 8'h00;
    exp[12] = 8'h00; exp[13] = 8'h0A; exp[14] = 8'hC5; exp[15] = 8'hCD;
    set_pay(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01);
    send_bytes(0, 6, 1'b1, ok);
    set_pay(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A);
    send_bytes(0, 6, 1'b1, ok2);
    src_idle();
    total++;
    if (!(ok && ok2)) begin bad++; $display("FAIL b2b_send: got timeout want handshake"); end
    wait_fd(f0 + 2, 3000, ok);
    @(negedge clk);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_fd_wait: got timeout want two frame_done"); end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (tx_log[t0 + k] !== exp[k]) begin
        bad++; $display("FAIL b2b_tx_byte%0d: got %h want %h", k, tx_log[t0 + k], exp[k]);
      end
    end
    total += 4;
    if (fd_cnt - f0 !== 2)  begin bad++; $display("FAIL b2b_fd_count: got %0d want 2", fd_cnt - f0); end
    if (gap_len < GAP + 1)  begin bad++; $display("FAIL b2b_gap_len: got %0d want >=%0d", gap_len, GAP + 1); end
    if (gap_rdy !== 0)      begin bad++; $display("FAIL b2b_gap_ready: got %0d want 0", gap_rdy); end
    if (eng_viol !== 0)     begin bad++; $display("FAIL b2b_engine: got %0d want 0", eng_viol); end
    wait_idle(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_idle: got busy want idle"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t0, f0;
    logic [7:0] exp [0:7];
    char_time = 0;
    set_pay(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A);
    exp[0] = 8'h01; exp[1] = 8'h03; exp[2] = 8'h00; exp[3] = 8'h00;
    exp[4] = 8'h00; exp[5] = 8'h0A; exp[6] = 8'hC5; exp[7] = 8'hCD;
    send_bytes(0, 3, 1'b0, ok);
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total += 8;
    if (!ok)                 begin bad++; $display("FAIL mid_send: got timeout want handshake"); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (s_ready !== 1'b0)    begin bad++; $display("FAIL mid_s_ready: got %b want 0", s_ready); end
    if (tx_start !== 1'b0)   begin bad++; $display("FAIL mid_tx_start: got %b want 0", tx_start); end
    if (crc_load !== 1'b0)   begin bad++; $display("FAIL mid_crc_load: got %b want 0", crc_load); end
    if (tx_data !== 8'h00)   begin bad++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
    if (crc_byte !== 8'h00)  begin bad++; $display("FAIL mid_crc_byte: got %h want 00", crc_byte); end
    if (err_len !== 1'b0)    begin bad++; $display("FAIL mid_err_len: got %b want 0", err_len); end
    rst = 1'b0;
    @(negedge clk);
    t0 = tx_cnt; f0 = fd_cnt;
    send_bytes(0, 6, 1'b1, ok);
    src_idle();
    wait_fd(f0 + 1, 2000, ok);
    @(negedge clk);
    total++;
    if (!ok) begin bad++; $display("FAIL mid_fd_wait: got timeout want frame_done"); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (tx_log[t0 + k] !== exp[k]) begin
        bad++; $display("FAIL mid_tx_byte%0d: got %h want %h", k, tx_log[t0 + k], exp[k]);
      end
    end
    total++;
    if (eng_viol !== 0) begin bad++; $display("FAIL mid_engine: got %0d want 0", eng_viol); end
    wait_idle(200, ok);
  endtask

  task automatic test_max_len();
    bit ok;
    int t0, f0;
    logic [7:0] exp [0:7];
    char_time = 0;
    t0 = tx_cnt; f0 = fd_cnt;
    set_pay(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A);
    exp[0] = 8'h01; exp[1] = 8'h03; exp[2] = 8'h00; exp[3] = 8'h00;
    exp[4] = 8'h00; exp[5] = 8'h0A; exp[6] = 8'hC5; exp[7] = 8'hCD;
    send_bytes(0, ML, 1'b0, ok);
    src_idle();
    wait_fd(f0 + 1, 2000, ok);
    @(negedge clk);
    total += 3;
    if (!ok)               begin bad++; $display("FAIL maxlen_fd_wait: got timeout want frame_done"); end
    if (err_len !== 1'b1)  begin bad++; $display("FAIL maxlen_err_set: got %b want 1", err_len); end
    if (tx_cnt - t0 !== 8) begin bad++; $display("FAIL maxlen_tx_count: got %0d want 8", tx_cnt - t0); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (tx_log[t0 + k] !== exp[k]) begin
        bad++; $display("FAIL maxlen_tx_byte%0d: got %h want %h", k, tx_log[t0 + k], exp[k]);
      end
    end
    wait_idle(200, ok);
    repeat (5) @(negedge clk);
    total++;
    if (err_len !== 1'b1) begin bad++; $display("FAIL maxlen_err_sticky: got %b want 1", err_len); end
    // Next frame start must clear the flag.
    t0 = tx_cnt; f0 = fd_cnt;
    set_pay(8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01);
    send_bytes(0, 1, 1'b0, ok);
    @(negedge clk);
    total++;
    if (err_len !== 1'b0) begin bad++; $display("FAIL maxlen_err_clear: got %b want 0", err_len); end
    send_bytes(1, 5, 1'b1, ok);
    src_idle();
    wait_fd(f0 + 1, 2000, ok);
    @(negedge clk);
    total += 4;
    if (!ok)                   begin bad++; $display("FAIL maxlen2_fd_wait: got timeout want frame_done"); end
    if (tx_log[t0 + 6] !== 8'h84) begin bad++; $display("FAIL maxlen2_crc_l: got %h want 84", tx_log[t0 + 6]); end
    if (tx_log[t0 + 7] !== 8'h0A) begin bad++; $display("FAIL maxlen2_crc_h: got %h want 0a", tx_log[t0 + 7]); end
    if (err_len !== 1'b0)      begin bad++; $display("FAIL maxlen2_err: got %b want 0", err_len); end
    wait_idle(200, ok);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_slow_uart();
    test_back_to_back();
    test_reset_mid();
    test_max_len();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
